voice_scheduler: RTL and testbench

- Sequencing controller between the song reader and a bank of NUM_VOICES note_player instances.
- Accepts note events over a valid/ready handshake and allocates each note to a free voice. When no voice is free, it steals one in round-robin order.
- Drives the shared note/duration load bus and the per-voice load strobes.
- Tracks voice occupancy from done_with_note and gates play_enable for the whole bank.

---
 rtl/voice_scheduler.sv | 132 +++++++++++++
 tb/tb_voice_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/voice_scheduler.sv
// voice_scheduler: accepts note events over a valid/ready handshake and
// allocates each non-rest note to a free note_player voice. When every voice
// is busy, one is stolen in round-robin order. The scheduler drives the shared
// note/duration load bus, the one-hot load strobes and the bank-wide play
// enable, and it tracks which voices are occupied.
//
// Handshake: an event transfers on a clock edge where note_valid and
// note_ready are both high. note_ready is high exactly in ACCEPT. The data
// must be held stable while note_valid is high. The load strobe follows one
// cycle after the transfer, in LOAD, so the fastest rate is one note every
// two cycles.
module voice_scheduler #(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play,
    input  logic                  note_valid,
    output logic                  note_ready,
    input  logic [NOTE_W-1:0]     note_in,
    input  logic [DUR_W-1:0]      duration_in,
    input  logic [NUM_VOICES-1:0] voice_done,
    output logic                  play_enable,
    output logic [NUM_VOICES-1:0] load_new_note,
    output logic [NOTE_W-1:0]     note_to_load,
    output logic [DUR_W-1:0]      duration_to_load,
    output logic [NUM_VOICES-1:0] voice_busy,
    output logic                  all_idle
);

    localparam int PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [PTR_W-1:0] LAST_VOICE = PTR_W'(NUM_VOICES - 1);
    localparam logic [NUM_VOICES-1:0] ONE_HOT_0 = NUM_VOICES'(1);

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        ACCEPT = 2'd1,
        LOAD   = 2'd2
    } state_t;

    state_t                  state;
    logic [PTR_W-1:0]        steal_ptr;
    logic [PTR_W-1:0]        chosen;
    logic                    any_free;
    logic [NUM_VOICES-1:0]   busy_after_done;
    logic                    handshake;
    logic                    is_rest;

    assign note_ready = (state == ACCEPT);
    assign all_idle   = (voice_busy == '0);
    assign handshake  = note_valid && note_ready;
    assign is_rest    = (note_in == '0);

    // Pick the lowest free voice; a voice finishing this cycle counts as free.
    // Falls back to the round-robin steal pointer when every voice is busy.
    always_comb begin
        busy_after_done = voice_busy & ~voice_done;
        any_free        = 1'b0;
        chosen          = steal_ptr;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!busy_after_done[i]) begin
                any_free = 1'b1;
                chosen   = PTR_W'(i);
            end
        end
    end

    // Control FSM with registered load bus, strobes and play enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= PAUSED;
            play_enable      <= 1'b0;
            load_new_note    <= '0;
            note_to_load     <= '0;
            duration_to_load <= '0;
            steal_ptr        <= '0;
        end else begin
            load_new_note <= '0;
            case (state)
                PAUSED: begin
                    if (play) begin
                        state       <= ACCEPT;
                        play_enable <= 1'b1;
                    end
                end
                ACCEPT: begin
                    if (handshake) begin
                        state            <= LOAD;
                        play_enable      <= 1'b1;
                        note_to_load     <= note_in;
                        duration_to_load <= duration_in;
                        // A rest touches no voice, so it neither strobes nor steals.
                        if (!is_rest) begin
                            load_new_note <= ONE_HOT_0 << chosen;
                            if (!any_free) begin
                                steal_ptr <= (steal_ptr == LAST_VOICE) ? '0 : steal_ptr + 1'b1;
                            end
                        end
                    end else if (!play) begin
                        state       <= PAUSED;
                        play_enable <= 1'b0;
                    end
                end
                LOAD: begin
                    if (play) begin
                        state       <= ACCEPT;
                        play_enable <= 1'b1;
                    end else begin
                        state       <= PAUSED;
                        play_enable <= 1'b0;
                    end
                end
                default: begin
                    state       <= PAUSED;
                    play_enable <= 1'b0;
                end
            endcase
        end
    end

    // Occupancy: a load sets the bit and wins over a simultaneous done.
    always_ff @(posedge clk) begin
        if (reset) begin
            voice_busy <= '0;
        end else begin
            voice_busy <= (voice_busy & ~voice_done) | load_new_note;
        end
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// tb_voice_scheduler: directed table of per-cycle vectors for voice_scheduler
// with hand-computed expectations, plus hand-written sequences for pausing in
// the handshake cycle and for reset during LOAD and during an accept.
module tb_voice_scheduler;

    logic       clk;
    logic       reset;
    logic       play;
    logic       note_valid;
    logic       note_ready;
    logic [5:0] note_in;
    logic [5:0] duration_in;
    logic [2:0] voice_done;
    logic       play_enable;
    logic [2:0] load_new_note;
    logic [5:0] note_to_load;
    logic [5:0] duration_to_load;
    logic [2:0] voice_busy;
    logic       all_idle;

    int checks = 0;
    int errors = 0;

    voice_scheduler #(
        .NUM_VOICES(3),
        .NOTE_W(6),
        .DUR_W(6)
    ) dut (
        .clk(clk),
        .reset(reset),
        .play(play),
        .note_valid(note_valid),
        .note_ready(note_ready),
        .note_in(note_in),
        .duration_in(duration_in),
        .voice_done(voice_done),
        .play_enable(play_enable),
        .load_new_note(load_new_note),
        .note_to_load(note_to_load),
        .duration_to_load(duration_to_load),
        .voice_busy(voice_busy),
        .all_idle(all_idle)
    );

    // Clock and a hard time limit.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       rst;
        logic       play;
        logic       valid;
        logic [5:0] note;
        logic [5:0] dur;
        logic [2:0] done;
        logic       exp_ready;
        logic [2:0] exp_load;
        logic [5:0] exp_note;
        logic [5:0] exp_dur;
        logic [2:0] exp_busy;
        logic       exp_pe;
        logic       exp_idle;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic pl, input logic vld,
                                input logic [5:0] nt, input logic [5:0] du, input logic [2:0] dn,
                                input logic e_rdy, input logic [2:0] e_ld, input logic [5:0] e_nt,
                                input logic [5:0] e_du, input logic [2:0] e_bz, input logic e_pe,
                                input logic e_idle);
        vec_t v;
        v.rst = rst; v.play = pl; v.valid = vld; v.note = nt; v.dur = du; v.done = dn;
        v.exp_ready = e_rdy; v.exp_load = e_ld; v.exp_note = e_nt; v.exp_dur = e_du;
        v.exp_busy = e_bz; v.exp_pe = e_pe; v.exp_idle = e_idle;
        return v;
    endfunction

    // Driver: set inputs just after the falling edge, let outputs settle.
    task automatic apply(input logic rst, input logic pl, input logic vld,
                         input logic [5:0] nt, input logic [5:0] du, input logic [2:0] dn);
        reset       = rst;
        play        = pl;
        note_valid  = vld;
        note_in     = nt;
        duration_in = du;
        voice_done  = dn;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // Reset block.
        apply(1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 3'b000);
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Phase A: single note to voice 0, then reset mid-run.
        tbl.push_back(mk(0,1,0,  0, 0,3'b000, 0,3'b000,  0, 0,3'b000,0,1));
        tbl.push_back(mk(0,1,1, 12, 8,3'b000, 1,3'b000,  0, 0,3'b000,1,1));
        tbl.push_back(mk(0,1,0,  0, 0,3'b000, 0,3'b001, 12, 8,3'b000,1,1));
        tbl.push_back(mk(0,1,0,  0, 0,3'b000, 1,3'b000, 12, 8,3'b001,1,0));
        tbl.push_back(mk(1,1,0,  0, 0,3'b000, 1,3'b000, 12, 8,3'b001,1,0));
        // Phase B: fill all three voices, then two steals.
        tbl.push_back(mk(0,1,0,  0, 0,3'b000, 0,3'b000,  0, 0,3'b000,0,1));
        tbl.push_back(mk(0,1,1,  5, 3,3'b000, 1,3'b000,  0, 0,3'b000,1,1));
        tbl.push_back(mk(0,1,1,  9, 6,3'b000, 0,3'b001,  5, 3,3'b000,1,1));
        tbl.push_back(mk(0,1,1,  9, 6,3'b000, 1,3'b000,  5, 3,3'b001,1,0));
        tbl.push_back(mk(0,1,1, 14, 2,3'b000, 0,3'b010,  9, 6,3'b001,1,0));
        tbl.push_back(mk(0,1,1, 14, 2,3'b000, 1,3'b000,  9, 6,3'b011,1,0));
        tbl.push_back(mk(0,1,1, 20, 5,3'b000, 0,3'b100, 14, 2,3'b011,1,0));
        tbl.push_back(mk(0,1,1, 20, 5,3'b000, 1,3'b000, 14, 2,3'b111,1,0));
        tbl.push_back(mk(0,1,1, 21, 7,3'b000, 0,3'b001, 20, 5,3'b111,1,0));
        tbl.push_back(mk(0,1,1, 21, 7,3'b000, 1,3'b000, 20, 5,3'b111,1,0));
        tbl.push_back(mk(0,1,0,  0, 0,3'b000, 0,3'b010, 21, 7,3'b111,1,0));
        // Done on voice 1 in the accept cycle: voice 1 reused, no steal.
        tbl.push_back(mk(0,1,1, 30, 9,3'b010, 1,3'b000, 21, 7,3'b111,1,0));
        tbl.push_back(mk(0,1,1, 31,10,3'b000, 0,3'b010, 30, 9,3'b101,1,0));
        // Next steal lands on voice 2, so the pointer was left at 2.
        tbl.push_back(mk(0,1,1, 31,10,3'b000, 1,3'b000, 30, 9,3'b111,1,0));
        tbl.push_back(mk(0,1,0,  0, 0,3'b000, 0,3'b100, 31,10,3'b111,1,0));
        // Rest: handshake, no strobe, busy untouched, ready again two cycles later.
        tbl.push_back(mk(0,1,1,  0, 4,3'b000, 1,3'b000, 31,10,3'b111,1,0));
        tbl.push_back(mk(0,1,0,  0, 0,3'b000, 0,3'b000,  0, 4,3'b111,1,0));
        tbl.push_back(mk(0,1,0,  0, 0,3'b000, 1,3'b000,  0, 4,3'b111,1,0));
        // Voice 2 freed at accept, then load and done on voice 2 together; duration 0 passes.
        tbl.push_back(mk(0,1,1, 40, 0,3'b100, 1,3'b000,  0, 4,3'b111,1,0));
        tbl.push_back(mk(0,1,0,  0, 0,3'b100, 0,3'b100, 40, 0,3'b011,1,0));
        tbl.push_back(mk(0,1,0,  0, 0,3'b000, 1,3'b000, 40, 0,3'b111,1,0));
        tbl.push_back(mk(0,1,0,  0, 0,3'b111, 1,3'b000, 40, 0,3'b111,1,0));
        tbl.push_back(mk(0,1,0,  0, 0,3'b000, 1,3'b000, 40, 0,3'b000,1,1));

        foreach (tbl[k]) begin
            apply(tbl[k].rst, tbl[k].play, tbl[k].valid, tbl[k].note, tbl[k].dur, tbl[k].done);
            chk($sformatf("v%0d note_ready", k),  32'(note_ready),       32'(tbl[k].exp_ready));
            chk($sformatf("v%0d load",       k),  32'(load_new_note),    32'(tbl[k].exp_load));
            chk($sformatf("v%0d note_bus",   k),  32'(note_to_load),     32'(tbl[k].exp_note));
            chk($sformatf("v%0d dur_bus",    k),  32'(duration_to_load), 32'(tbl[k].exp_dur));
            chk($sformatf("v%0d busy",       k),  32'(voice_busy),       32'(tbl[k].exp_busy));
            chk($sformatf("v%0d play_en",    k),  32'(play_enable),      32'(tbl[k].exp_pe));
            chk($sformatf("v%0d all_idle",   k),  32'(all_idle),         32'(tbl[k].exp_idle));
            tick();
        end

        // Play drops in the handshake cycle: LOAD still strobes, then pause.
        apply(1'b0, 1'b0, 1'b1, 6'd7, 6'd11, 3'b000);
        chk("pd accept ready", 32'(note_ready), 32'd1);
        tick();
        apply(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 3'b000);
        chk("pd load ready", 32'(note_ready), 32'd0);
        chk("pd load strobe", 32'(load_new_note), 32'b001);
        chk("pd load note", 32'(note_to_load), 32'd7);
        chk("pd load dur", 32'(duration_to_load), 32'd11);
        chk("pd load play_en", 32'(play_enable), 32'd1);
        tick();
        apply(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 3'b000);
        chk("pd paused ready", 32'(note_ready), 32'd0);
        chk("pd paused play_en", 32'(play_enable), 32'd0);
        chk("pd paused strobe", 32'(load_new_note), 32'b000);
        chk("pd paused busy", 32'(voice_busy), 32'b001);
        tick();
        apply(1'b0, 1'b0, 1'b1, 6'd3, 6'd3, 3'b000);
        chk("pd hold ready", 32'(note_ready), 32'd0);
        chk("pd hold play_en", 32'(play_enable), 32'd0);
        chk("pd hold busy", 32'(voice_busy), 32'b001);
        tick();

        // Resume, accept a note, assert reset during LOAD.
        apply(1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 3'b000);
        chk("rl paused ready", 32'(note_ready), 32'd0);
        tick();
        apply(1'b0, 1'b1, 1'b1, 6'd8, 6'd12, 3'b000);
        chk("rl accept ready", 32'(note_ready), 32'd1);
        chk("rl accept play_en", 32'(play_enable), 32'd1);
        tick();
        apply(1'b1, 1'b1, 1'b0, 6'd0, 6'd0, 3'b000);
        chk("rl load ready", 32'(note_ready), 32'd0);
        chk("rl load note", 32'(note_to_load), 32'd8);
        tick();
        apply(1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 3'b000);
        chk("rl after ready", 32'(note_ready), 32'd0);
        chk("rl after strobe", 32'(load_new_note), 32'b000);
        chk("rl after note", 32'(note_to_load), 32'd0);
        chk("rl after dur", 32'(duration_to_load), 32'd0);
        chk("rl after busy", 32'(voice_busy), 32'b000);
        chk("rl after play_en", 32'(play_enable), 32'd0);
        chk("rl after all_idle", 32'(all_idle), 32'd1);
        tick();

        // Reset in the accept cycle aborts the pending load.
        apply(1'b1, 1'b1, 1'b1, 6'd9, 6'd1, 3'b000);
        chk("ra accept ready", 32'(note_ready), 32'd1);
        tick();
        apply(1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 3'b000);
        chk("ra after strobe", 32'(load_new_note), 32'b000);
        chk("ra after ready", 32'(note_ready), 32'd0);
        chk("ra after note", 32'(note_to_load), 32'd0);
        chk("ra after busy", 32'(voice_busy), 32'b000);
        chk("ra after play_en", 32'(play_enable), 32'd0);
        tick();
        apply(1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 3'b000);
        chk("ra next strobe", 32'(load_new_note), 32'b000);
        chk("ra next ready", 32'(note_ready), 32'd1);
        chk("ra next play_en", 32'(play_enable), 32'd1);
        tick();

        // Final report.
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
